dac_write_seq: RTL and testbench

//  Parametrised write sequencer for parallel-input multi-channel DACs (AD7302-class: addr/CS/WR/LDAC bus).

---
 rtl/dac_write_seq.sv | 225 ++++++++++++++++++++++
 tb/tb_dac_write_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_write_seq.sv
// Write sequencer for parallel-input multi-channel DACs: handshake in, timed CS_n/WR_n strobes out,
// per-channel shadow readback. Optional simultaneous-update LDAC pulse when DAC_SYNC_LDAC_EN is defined.
module dac_write_seq #(
  parameter int DW    = 8,
  parameter int NCH   = 2,
  parameter int CH_W  = 1,
  parameter int T_SU  = 4,
  parameter int T_WR  = 50,
  parameter int T_HD  = 30,
  parameter int T_GAP = 200,
  parameter int T_LD  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [CH_W-1:0] req_ch,
  input  logic [DW-1:0]   req_data,
  input  logic            ldac_req,
  output logic [CH_W-1:0] dac_addr,
  output logic [DW-1:0]   dac_d,
  output logic            cs_n,
  output logic            wr_n,
  output logic            ldac_n,
  output logic            busy,
  output logic            err,
  input  logic [CH_W-1:0] rd_ch,
  output logic [DW-1:0]   rd_data
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_WRITE, S_HOLD, S_GAP} state_t;

  localparam logic [CH_W:0] NCH_L   = (CH_W+1)'(NCH);
  localparam logic [15:0]   SU_END  = 16'(T_SU - 1);
  localparam logic [15:0]   WR_END  = 16'(T_WR - 1);
  localparam logic [15:0]   HD_END  = 16'(T_HD - 1);
  localparam logic [15:0]   GAP_END = 16'(T_GAP - 1);

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [CH_W-1:0] dac_addr_q, dac_addr_d;
  logic [DW-1:0]   dac_d_q, dac_d_d;
  logic            cs_n_q, cs_n_d;
  logic            wr_n_q, wr_n_d;
  logic            err_q, err_d;
  logic            shadow_we;
  logic            ldac_block;
  logic            accept;
  logic            ch_ok;
  logic [DW-1:0]   shadow_q [2**CH_W];

  assign req_ready = (state_q == S_IDLE) && !ldac_block;
  assign accept    = req_valid && req_ready;
  assign ch_ok     = ({1'b0, req_ch} < NCH_L);

  // State register and registered bus/strobe outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      dac_addr_q <= '0;
      dac_d_q    <= '0;
      cs_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dac_addr_q <= dac_addr_d;
      dac_d_q    <= dac_d_d;
      cs_n_q     <= cs_n_d;
      wr_n_q     <= wr_n_d;
      err_q      <= err_d;
    end
  end

  // Next-state, phase counter and request latching
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    dac_addr_d = dac_addr_q;
    dac_d_d    = dac_d_q;
    err_d      = 1'b0;
    shadow_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        if (accept && ch_ok) begin
          state_d    = S_SETUP;
          dac_addr_d = req_ch;
          dac_d_d    = req_data;
          shadow_we  = 1'b1;
        end else if (accept) begin
          err_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_q == SU_END) begin
          state_d = S_WRITE;
          cnt_d   = 16'd0;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_WRITE: begin
        if (cnt_q == WR_END) begin
          state_d = S_HOLD;
          cnt_d   = 16'd0;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_HOLD: begin
        if (cnt_q == HD_END) begin
          state_d = S_GAP;
          cnt_d   = 16'd0;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_END) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end else begin
          state_d = S_GAP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Strobes decoded from the next state so they register glitch-free alongside it
  always_comb begin
    cs_n_d = 1'b1;
    wr_n_d = 1'b1;
    case (state_d)
      S_IDLE:  begin cs_n_d = 1'b1; wr_n_d = 1'b1; end
      S_SETUP: begin cs_n_d = 1'b0; wr_n_d = 1'b1; end
      S_WRITE: begin cs_n_d = 1'b0; wr_n_d = 1'b0; end
      S_HOLD:  begin cs_n_d = 1'b0; wr_n_d = 1'b1; end
      S_GAP:   begin cs_n_d = 1'b1; wr_n_d = 1'b1; end
      default: begin cs_n_d = 1'b1; wr_n_d = 1'b1; end
    endcase
  end

  // Shadow registers; entries at or above NCH are never written and stay zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**CH_W; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (shadow_we) begin
      shadow_q[req_ch] <= req_data;
    end
  end

  assign rd_data  = ({1'b0, rd_ch} < NCH_L) ? shadow_q[rd_ch] : '0;
  assign dac_addr = dac_addr_q;
  assign dac_d    = dac_d_q;
  assign cs_n     = cs_n_q;
  assign wr_n     = wr_n_q;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

`ifdef DAC_SYNC_LDAC_EN
  localparam logic [15:0] LD_END = 16'(T_LD - 1);

  logic        pend_q, pend_d;
  logic        ld_act_q, ld_act_d;
  logic [15:0] ld_cnt_q, ld_cnt_d;
  logic        ldac_n_q, ldac_n_d;
  logic        ld_start;

  // LDAC pending flag and pulse timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q   <= 1'b0;
      ld_act_q <= 1'b0;
      ld_cnt_q <= 16'd0;
      ldac_n_q <= 1'b1;
    end else begin
      pend_q   <= pend_d;
      ld_act_q <= ld_act_d;
      ld_cnt_q <= ld_cnt_d;
      ldac_n_q <= ldac_n_d;
    end
  end

  // A pending update fires only once the sequencer is idle, so an in-flight write lands first
  always_comb begin
    ld_start = pend_q && (state_q == S_IDLE) && !ld_act_q;
    pend_d   = (pend_q && !ld_start) || ldac_req;
    if (ld_start) begin
      ld_act_d = 1'b1;
      ld_cnt_d = 16'd0;
    end else if (ld_act_q && (ld_cnt_q == LD_END)) begin
      ld_act_d = 1'b0;
      ld_cnt_d = 16'd0;
    end else if (ld_act_q) begin
      ld_act_d = 1'b1;
      ld_cnt_d = ld_cnt_q + 16'd1;
    end else begin
      ld_act_d = 1'b0;
      ld_cnt_d = 16'd0;
    end
    ldac_n_d = !ld_act_d;
  end

  assign ldac_block = pend_q || ld_act_q;
  assign ldac_n     = ldac_n_q;
`else
  logic unused_ldac_req;

  assign unused_ldac_req = ldac_req;
  assign ldac_block      = 1'b0;
  assign ldac_n          = 1'b0;
`endif

endmodule

// File: tb/tb_dac_write_seq.sv
// Directed bench for dac_write_seq: default-timing instance for strobe timing, back-to-back and reset,
// plus a 3-channel unit-timing instance driven from a vector table for range/err behaviour.
module tb_dac_write_seq;

`ifdef DAC_SYNC_LDAC_EN
  localparam logic LD_IDLE = 1'b1;
`else
  localparam logic LD_IDLE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       a_req_valid, a_req_ready, a_ldac_req, a_cs_n, a_wr_n, a_ldac_n, a_busy, a_err;
  logic [0:0] a_req_ch, a_dac_addr, a_rd_ch;
  logic [7:0] a_req_data, a_dac_d, a_rd_data;

  logic       b_req_valid, b_req_ready, b_ldac_req, b_cs_n, b_wr_n, b_ldac_n, b_busy, b_err;
  logic [1:0] b_req_ch, b_dac_addr, b_rd_ch;
  logic [7:0] b_req_data, b_dac_d, b_rd_data;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  dac_write_seq u_dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready), .req_ch(a_req_ch),
    .req_data(a_req_data), .ldac_req(a_ldac_req), .dac_addr(a_dac_addr), .dac_d(a_dac_d),
    .cs_n(a_cs_n), .wr_n(a_wr_n), .ldac_n(a_ldac_n), .busy(a_busy), .err(a_err),
    .rd_ch(a_rd_ch), .rd_data(a_rd_data)
  );

  dac_write_seq #(.NCH(3), .CH_W(2), .T_SU(1), .T_WR(1), .T_HD(1), .T_GAP(1)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_ch(b_req_ch),
    .req_data(b_req_data), .ldac_req(b_ldac_req), .dac_addr(b_dac_addr), .dac_d(b_dac_d),
    .cs_n(b_cs_n), .wr_n(b_wr_n), .ldac_n(b_ldac_n), .busy(b_busy), .err(b_err),
    .rd_ch(b_rd_ch), .rd_data(b_rd_data)
  );

  typedef struct {
    logic [1:0] ch;
    logic [7:0] data;
    logic       exp_err;
    int         exp_busy;
    int         exp_cs;
    int         exp_wr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t       vecs [6];
    logic [7:0] exp_sh [4];
    int cs_low, wr_low, busy_n, su_n, bus_bad, ready_bad, ld_bad, err_n;
    int n_acc, not_ready, ld_low, ld_low_busy, ready_in_ld;
    int acc_cyc [2];

    vecs[0] = '{ch: 2'd0, data: 8'h11, exp_err: 1'b0, exp_busy: 4, exp_cs: 3, exp_wr: 1};
    vecs[1] = '{ch: 2'd2, data: 8'h3C, exp_err: 1'b0, exp_busy: 4, exp_cs: 3, exp_wr: 1};
    vecs[2] = '{ch: 2'd3, data: 8'hFF, exp_err: 1'b1, exp_busy: 0, exp_cs: 0, exp_wr: 0};
    vecs[3] = '{ch: 2'd1, data: 8'h7E, exp_err: 1'b0, exp_busy: 4, exp_cs: 3, exp_wr: 1};
    vecs[4] = '{ch: 2'd3, data: 8'h22, exp_err: 1'b1, exp_busy: 0, exp_cs: 0, exp_wr: 0};
    vecs[5] = '{ch: 2'd2, data: 8'hC3, exp_err: 1'b0, exp_busy: 4, exp_cs: 3, exp_wr: 1};
    for (int i = 0; i < 4; i++) exp_sh[i] = 8'h00;

    a_req_valid = 1'b0; a_req_ch = 1'b0; a_req_data = 8'h00; a_ldac_req = 1'b0; a_rd_ch = 1'b0;
    b_req_valid = 1'b0; b_req_ch = 2'd0; b_req_data = 8'h00; b_ldac_req = 1'b0; b_rd_ch = 2'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", a_cs_n, 1'b1);
    chk("rst_wr_n", a_wr_n, 1'b1);
    chk("rst_dac_d", a_dac_d, 8'h00);
    chk("rst_dac_addr", a_dac_addr, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_ldac_n", a_ldac_n, LD_IDLE);
    rst = 1'b1;
    tick;

    // Single write, default timing
    a_req_ch = 1'b1; a_req_data = 8'hA5; a_req_valid = 1'b1;
    chk("t2_ready", a_req_ready, 1'b1);
    tick;
    a_req_valid = 1'b0;
    cs_low = 0; wr_low = 0; busy_n = 0; su_n = 0; bus_bad = 0; ready_bad = 0; ld_bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (!a_cs_n) begin
        cs_low++;
        if (a_dac_addr !== 1'b1 || a_dac_d !== 8'hA5) bus_bad++;
        if (a_wr_n && wr_low == 0) su_n++;
      end
      if (!a_wr_n) wr_low++;
      if (a_busy) begin
        busy_n++;
        if (a_req_ready) ready_bad++;
      end
      if (a_ldac_n !== LD_IDLE) ld_bad++;
      tick;
    end
    chk("t2_cs_low", cs_low, 84);
    chk("t2_wr_low", wr_low, 50);
    chk("t2_setup", su_n, 4);
    chk("t2_busy", busy_n, 284);
    chk("t2_bus_stable", bus_bad, 0);
    chk("t2_ready_while_busy", ready_bad, 0);
    chk("t2_ldac_idle", ld_bad, 0);
    a_rd_ch = 1'b1; #1;
    chk("t2_rd_ch1", a_rd_data, 8'hA5);
    a_rd_ch = 1'b0; #1;
    chk("t2_rd_ch0", a_rd_data, 8'h00);

    // Back-to-back with req_valid held
    a_req_ch = 1'b0; a_req_data = 8'h10; a_req_valid = 1'b1;
    n_acc = 0; not_ready = 0; acc_cyc[0] = 0; acc_cyc[1] = 0;
    for (int c = 0; c < 700 && n_acc < 2; c++) begin
      if (a_req_ready) begin
        acc_cyc[n_acc] = c;
        n_acc++;
      end else begin
        not_ready++;
      end
      tick;
      if (n_acc == 1) begin a_req_ch = 1'b1; a_req_data = 8'hF0; end
      if (n_acc == 2) a_req_valid = 1'b0;
    end
    a_req_valid = 1'b0;
    chk("t3_accepts", n_acc, 2);
    chk("t3_first_at_once", acc_cyc[0], 0);
    chk("t3_spacing", acc_cyc[1] - acc_cyc[0], 285);
    chk("t3_not_ready", not_ready, 284);
    repeat (290) tick;
    a_rd_ch = 1'b0; #1;
    chk("t3_rd_ch0", a_rd_data, 8'h10);
    a_rd_ch = 1'b1; #1;
    chk("t3_rd_ch1", a_rd_data, 8'hF0);
    chk("t3_bus_addr_hold", a_dac_addr, 1'b1);
    chk("t3_bus_data_hold", a_dac_d, 8'hF0);
    chk("t3_cs_idle", a_cs_n, 1'b1);

    // LDAC request during WRITE
    a_req_ch = 1'b0; a_req_data = 8'h33; a_req_valid = 1'b1;
    tick;
    a_req_valid = 1'b0;
    repeat (10) tick;
    chk("t6_in_write", a_wr_n, 1'b0);
    a_ldac_req = 1'b1;
    tick;
    a_ldac_req = 1'b0;
    ld_low = 0; ld_low_busy = 0; ready_in_ld = 0;
    for (int i = 0; i < 400; i++) begin
      if (!a_ldac_n) begin
        ld_low++;
        if (a_busy) ld_low_busy++;
        if (a_req_ready) ready_in_ld++;
      end
      tick;
    end
`ifdef DAC_SYNC_LDAC_EN
    chk("t6_ldac_low", ld_low, 8);
    chk("t6_ldac_while_busy", ld_low_busy, 0);
    chk("t6_ready_in_pulse", ready_in_ld, 0);
`else
    chk("t6_ldac_low", ld_low, 400);
    chk("t6_ldac_while_busy", ld_low_busy, 273);
    chk("t6_ready_in_pulse", ready_in_ld, 127);
`endif
    chk("t6_ready_after", a_req_ready, 1'b1);
    a_rd_ch = 1'b0; #1;
    chk("t6_rd_ch0", a_rd_data, 8'h33);

    // Reset asserted mid-WRITE
    a_req_ch = 1'b1; a_req_data = 8'h5A; a_req_valid = 1'b1;
    tick;
    a_req_valid = 1'b0;
    repeat (10) tick;
    chk("t1_wr_active", a_wr_n, 1'b0);
    chk("t1_cs_active", a_cs_n, 1'b0);
    chk("t1_d_active", a_dac_d, 8'h5A);
    #2;
    rst = 1'b0;
    #1;
    chk("t1_cs_n", a_cs_n, 1'b1);
    chk("t1_wr_n", a_wr_n, 1'b1);
    chk("t1_dac_d", a_dac_d, 8'h00);
    chk("t1_busy", a_busy, 1'b0);
    tick;
    rst = 1'b1;
    tick;
    a_rd_ch = 1'b0; #1;
    chk("t1_rd_ch0", a_rd_data, 8'h00);
    a_rd_ch = 1'b1; #1;
    chk("t1_rd_ch1", a_rd_data, 8'h00);

    // Vector table on 3-channel unit-timing instance
    for (int v = 0; v < 6; v++) begin
      b_req_ch = vecs[v].ch; b_req_data = vecs[v].data; b_req_valid = 1'b1;
      chk($sformatf("v%0d_ready", v), b_req_ready, 1'b1);
      tick;
      b_req_valid = 1'b0;
      err_n = 0; busy_n = 0; cs_low = 0; wr_low = 0;
      for (int k = 0; k < 10; k++) begin
        if (b_err) err_n++;
        if (b_busy) busy_n++;
        if (!b_cs_n) cs_low++;
        if (!b_wr_n) wr_low++;
        tick;
      end
      chk($sformatf("v%0d_err", v), err_n, vecs[v].exp_err ? 1 : 0);
      chk($sformatf("v%0d_busy", v), busy_n, vecs[v].exp_busy);
      chk($sformatf("v%0d_cs_low", v), cs_low, vecs[v].exp_cs);
      chk($sformatf("v%0d_wr_low", v), wr_low, vecs[v].exp_wr);
      if (!vecs[v].exp_err) exp_sh[vecs[v].ch] = vecs[v].data;
      for (int r = 0; r < 4; r++) begin
        b_rd_ch = 2'(r); #1;
        chk($sformatf("v%0d_rd%0d", v, r), b_rd_data, exp_sh[r]);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
